// File: rtl/flash_arb_if.sv
// Bundles the two requester ports and the flash-reader port of flash_arb.
// The arbiter uses the slave modport; requesters and the flash model use master.
interface flash_arb_if;
  logic        rq0_valid;
  logic [23:0] rq0_addr;
  logic        rq0_ready;
  logic [7:0]  rq0_data;
  logic        rq0_err;
  logic        rq1_valid;
  logic [23:0] rq1_addr;
  logic        rq1_ready;
  logic [7:0]  rq1_data;
  logic        rq1_err;
  logic [23:0] fd_address;
  logic        fd_valid;
  logic [7:0]  fd;
  logic        fd_ready;
  logic        busy;

  modport slave (
    input  rq0_valid, rq0_addr, rq1_valid, rq1_addr, fd, fd_ready,
    output rq0_ready, rq0_data, rq0_err, rq1_ready, rq1_data, rq1_err,
    output fd_address, fd_valid, busy
  );

  modport master (
    output rq0_valid, rq0_addr, rq1_valid, rq1_addr, fd, fd_ready,
    input  rq0_ready, rq0_data, rq0_err, rq1_ready, rq1_data, rq1_err,
    input  fd_address, fd_valid, busy
  );
endinterface

// File: rtl/flash_arb.sv
// Round-robin arbiter sharing one flash byte reader between two requesters,
// with a 255-cycle timeout that returns 8'hFF and flags an error.
module flash_arb (
  input  logic        clk,
  input  logic        rstn,
  flash_arb_if.slave  arb_if
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  data0_q, data0_d, data1_q, data1_d;
  logic        err0_q, err0_d, err1_q, err1_d;

  logic        pick1;
  logic [7:0]  cnt_inc;
  logic        load;
  logic [7:0]  ld_data;
  logic        ld_err;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data0_d = data0_q;
    data1_d = data1_q;
    err0_d  = err0_q;
    err1_d  = err1_q;
    pick1   = 1'b0;
    cnt_inc = cnt_q + 8'd1;
    load    = 1'b0;
    ld_data = 8'h00;
    ld_err  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arb_if.rq0_valid || arb_if.rq1_valid) begin
          // Requester 1 wins alone, or on a tie when requester 0 was granted last.
          pick1   = arb_if.rq1_valid && (!arb_if.rq0_valid || !last_q);
          gnt_d   = pick1;
          last_d  = pick1;
          addr_d  = pick1 ? arb_if.rq1_addr : arb_if.rq0_addr;
          cnt_d   = 8'd0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (arb_if.fd_ready) begin
          load    = 1'b1;
          ld_data = arb_if.fd;
          state_d = StDone;
        end else if (cnt_inc == 8'hFF) begin
          load    = 1'b1;
          ld_data = 8'hFF;
          ld_err  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (load) begin
      if (gnt_q) begin
        data1_d = ld_data;
        err1_d  = ld_err;
      end else begin
        data0_d = ld_data;
        err0_d  = ld_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= 24'h0;
      cnt_q   <= 8'h0;
      data0_q <= 8'h00;
      data1_q <= 8'h00;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
    end
  end

  assign arb_if.fd_valid   = (state_q == StReq);
  assign arb_if.busy       = (state_q != StIdle);
  assign arb_if.fd_address = addr_q;
  assign arb_if.rq0_ready  = (state_q == StDone) && !gnt_q;
  assign arb_if.rq1_ready  = (state_q == StDone) && gnt_q;
  assign arb_if.rq0_data   = data0_q;
  assign arb_if.rq0_err    = err0_q;
  assign arb_if.rq1_data   = data1_q;
  assign arb_if.rq1_err    = err1_q;

endmodule
